// File: rtl/shift_pkg.sv
// shift_pkg: shared widths, command payload and helpers for the rotate
// command queue.
// Optional feature macro: SHIFT_DIR_EN (adds a direction bit to each command).
package shift_pkg;

   localparam int unsigned SH_W   = 4;
   localparam int unsigned SH_N_W = 2;

   // One queued rotate command.
   typedef struct packed {
      logic [SH_W-1:0]   a;
      logic [SH_N_W-1:0] n;
`ifdef SHIFT_DIR_EN
      logic              dir;
`endif
   } shift_cmd_t;

   // A left rotate by n equals a right rotate by (SH_W - n) mod SH_W.
   function automatic logic [SH_N_W-1:0] left_to_right_n(input logic [SH_N_W-1:0] n);
      return SH_N_W'(SH_W - 32'(n));
   endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// shift_cmd_fifo: synchronous FIFO of shift_cmd_t commands.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write request and payload (ignored when full)
//   pop               read request (ignored when empty)
//   head              entry at the read pointer
//   empty_c           no entries held
//   count             number of entries held (0..DEPTH)
// Optional feature macro: SHIFT_DIR_EN (widens shift_cmd_t by one bit).
module shift_cmd_fifo
   import shift_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  shift_cmd_t               push_data,
   input  logic                     pop,
   output shift_cmd_t               head,
   output logic                     empty_c,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   shift_cmd_t    mem_q [DEPTH];
   shift_cmd_t    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full;
   logic          do_push;
   logic          do_pop;

   // Pointers wrap naturally because DEPTH is a power of two; count qualifies them.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      full     = (count_q == CW'(DEPTH));
      empty_c  = (count_q == '0);
      do_push  = push && !full;
      do_pop   = pop && !empty_c;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue: buffers rotate commands, drives an external 4-bit barrel
// rotator from a registered issue stage and captures its result into a
// registered valid/ready output. Commands complete in order, one per cycle.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_a, cmd_n                    word to rotate, rotate amount
//   cmd_dir                         0 = right, 1 = left (SHIFT_DIR_EN only)
//   sh_a, sh_n                      registered rotator inputs
//   sh_sho                          rotator result (combinational from sh_a/sh_n)
//   res_valid/res_ready, res_data   result handshake and rotated word
// Optional feature macro: SHIFT_DIR_EN (adds cmd_dir and per-entry direction).
module shift_cmd_queue
   import shift_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [SH_W-1:0]   cmd_a,
   input  logic [SH_N_W-1:0] cmd_n,
`ifdef SHIFT_DIR_EN
   input  logic              cmd_dir,
`endif
   output logic [SH_W-1:0]   sh_a,
   output logic [SH_N_W-1:0] sh_n,
   input  logic [SH_W-1:0]   sh_sho,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [SH_W-1:0]   res_data
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic              iss_valid_q, iss_valid_d;
   logic [SH_W-1:0]   sh_a_q, sh_a_d;
   logic [SH_N_W-1:0] sh_n_q, sh_n_d;
   logic              res_valid_q, res_valid_d;
   logic [SH_W-1:0]   res_data_q, res_data_d;

   shift_cmd_t        push_cmd;
   shift_cmd_t        head_cmd;
   logic [SH_N_W-1:0] head_n;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic              fifo_push;
   logic              retire;
   logic              load;

   shift_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (push_cmd),
      .pop       (load),
      .head      (head_cmd),
      .empty_c   (fifo_empty),
      .count     (fifo_count)
   );

   // No pass-through: a full queue refuses even when it pops this cycle.
   assign cmd_ready = (fifo_count != CW'(DEPTH));
   assign fifo_push = cmd_valid && cmd_ready;

   // Command packing and amount normalisation for the rotator (right rotate only).
   always_comb begin
      push_cmd   = '0;
      push_cmd.a = cmd_a;
      push_cmd.n = cmd_n;
`ifdef SHIFT_DIR_EN
      push_cmd.dir = cmd_dir;
      head_n       = head_cmd.dir ? left_to_right_n(head_cmd.n) : head_cmd.n;
`else
      head_n       = head_cmd.n;
`endif
   end

   // Issue and result stage next-state.
   always_comb begin
      iss_valid_d = iss_valid_q;
      sh_a_d      = sh_a_q;
      sh_n_d      = sh_n_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      retire      = iss_valid_q && (!res_valid_q || res_ready);
      load        = !fifo_empty && (!iss_valid_q || retire);

      if (retire) begin
         res_data_d  = sh_sho;
         res_valid_d = 1'b1;
         iss_valid_d = 1'b0;
      end else if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end

      if (load) begin
         iss_valid_d = 1'b1;
         sh_a_d      = head_cmd.a;
         sh_n_d      = head_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_valid_q <= 1'b0;
         sh_a_q      <= '0;
         sh_n_q      <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         iss_valid_q <= iss_valid_d;
         sh_a_q      <= sh_a_d;
         sh_n_q      <= sh_n_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   assign sh_a      = sh_a_q;
   assign sh_n      = sh_n_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;

endmodule

// File: tb/tb_shift_cmd_queue.sv
// tb_shift_cmd_queue: directed bench for shift_cmd_queue with a behavioural
// right-rotator wired between sh_a/sh_n and sh_sho.
// Optional feature macro: SHIFT_DIR_EN (connects cmd_dir, runs direction vectors).
module tb_shift_cmd_queue;

   typedef struct {
      logic [3:0] a;
      logic [1:0] n;
      logic [3:0] exp;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_a;
   logic [1:0] cmd_n;
`ifdef SHIFT_DIR_EN
   logic       cmd_dir;
`endif
   logic [3:0] sh_a;
   logic [1:0] sh_n;
   logic [3:0] sh_sho;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_data;
   logic [7:0] rot_dbl;

   int checks = 0;
   int errors = 0;
   vec_t vecs [8];

   shift_cmd_queue #(
      .DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_n     (cmd_n),
`ifdef SHIFT_DIR_EN
      .cmd_dir   (cmd_dir),
`endif
      .sh_a      (sh_a),
      .sh_n      (sh_n),
      .sh_sho    (sh_sho),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data)
   );

   // External rotator: sh_sho[i] = sh_a[(i + sh_n) mod 4].
   assign rot_dbl = {sh_a, sh_a} >> sh_n;
   assign sh_sho  = rot_dbl[3:0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int idx);
      cmd_valid = v;
      cmd_a     = vecs[idx].a;
      cmd_n     = vecs[idx].n;
   endtask

   // Collect n_res results in order with res_ready high; the first edge also
   // checks the queue occupancy and stops driving commands.
   task automatic drain(input int n_res, input int cnt_exp);
      int got = 0;
      for (int cyc = 0; cyc < 20 && got < n_res; cyc++) begin
         if (res_valid) begin
            check("drain_data", 32'(res_data), 32'(vecs[got].exp));
            got++;
         end
         step();
         if (cyc == 0) begin
            cmd_valid = 1'b0;
            check("count_after_edge", 32'(dut.fifo_count), 32'(cnt_exp));
         end
      end
      check("drain_count", 32'(got), 32'(n_res));
      check("drain_res_valid_low", 32'(res_valid), 32'd0);
   endtask

   initial begin
      int acc;
      logic took;

      vecs[0] = '{4'b1011, 2'd0, 4'b1011};
      vecs[1] = '{4'b1011, 2'd1, 4'b1101};
      vecs[2] = '{4'b1011, 2'd2, 4'b1110};
      vecs[3] = '{4'b1011, 2'd3, 4'b0111};
      vecs[4] = '{4'b1000, 2'd1, 4'b0100};
      vecs[5] = '{4'b0110, 2'd2, 4'b1001};
      vecs[6] = '{4'b1100, 2'd3, 4'b1001};
      vecs[7] = '{4'b0101, 2'd1, 4'b1010};

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_n     = '0;
      res_ready = 1'b0;
`ifdef SHIFT_DIR_EN
      cmd_dir   = 1'b0;
`endif
      #2;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_sh_a", 32'(sh_a), 32'd0);
      check("rst_sh_n", 32'(sh_n), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Single command latency: push at edge k, result after edge k+2.
      cmd_valid = 1'b1;
      cmd_a     = 4'b0001;
      cmd_n     = 2'd1;
      step();
      cmd_valid = 1'b0;
      check("lat_k_res_valid", 32'(res_valid), 32'd0);
      step();
      check("lat_k1_res_valid", 32'(res_valid), 32'd0);
      check("lat_k1_sh_a", 32'(sh_a), 32'b0001);
      check("lat_k1_sh_n", 32'(sh_n), 32'd1);
      step();
      check("lat_k2_res_valid", 32'(res_valid), 32'd1);
      check("lat_k2_res_data", 32'(res_data), 32'b1000);
      res_ready = 1'b1;
      step();
      check("lat_consumed", 32'(res_valid), 32'd0);

      // Full throughput through the vector table.
      for (int c = 0; c < 10; c++) begin
         if (c < 8) drive(1'b1, c);
         else cmd_valid = 1'b0;
         step();
         if (c >= 2) begin
            check("tput_valid", 32'(res_valid), 32'd1);
            check("tput_data", 32'(res_data), 32'(vecs[c-2].exp));
         end
      end
      cmd_valid = 1'b0;
      step();
      check("tput_idle", 32'(res_valid), 32'd0);

      // Backpressure: result + issue + DEPTH entries before cmd_ready drops.
      res_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         took = 1'b0;
         if (cmd_ready && acc < 8) begin
            drive(1'b1, acc);
            took = 1'b1;
         end else begin
            cmd_valid = 1'b0;
         end
         step();
         if (took) acc++;
      end
      cmd_valid = 1'b0;
      check("bp_accepted", 32'(acc), 32'd6);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      for (int r = 0; r < 2; r++) begin
         check("bp_sh_a", 32'(sh_a), 32'(vecs[1].a));
         check("bp_sh_n", 32'(sh_n), 32'(vecs[1].n));
         check("bp_res_valid", 32'(res_valid), 32'd1);
         check("bp_res_data", 32'(res_data), 32'(vecs[0].exp));
         step();
         step();
      end
      // Full queue refuses a command even though it pops this cycle.
      res_ready = 1'b1;
      drive(1'b1, 6);
      #1;
      check("full_pop_cmd_ready", 32'(cmd_ready), 32'd0);
      drain(6, 3);

      // Push and pop together at count 2 leaves count at 2.
      res_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, c);
         step();
      end
      cmd_valid = 1'b0;
      step();
      step();
      check("cnt2_before", 32'(dut.fifo_count), 32'd2);
      res_ready = 1'b1;
      drive(1'b1, 4);
      #1;
      check("cnt2_cmd_ready", 32'(cmd_ready), 32'd1);
      drain(5, 2);

      // Asynchronous reset with three commands in flight.
      res_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, c + 1);
         step();
      end
      cmd_valid = 1'b0;
      check("pre_rst_res_valid", 32'(res_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_res_valid", 32'(res_valid), 32'd0);
      check("arst_sh_a", 32'(sh_a), 32'd0);
      check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("arst_res_data", 32'(res_data), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      res_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         check("post_rst_no_stale", 32'(res_valid), 32'd0);
      end

`ifdef SHIFT_DIR_EN
      // Left commands are converted to an equivalent right amount.
      cmd_valid = 1'b1;
      cmd_a     = 4'b0001;
      cmd_n     = 2'd1;
      cmd_dir   = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      check("dir_l1_sh_n", 32'(sh_n), 32'd3);
      step();
      check("dir_l1_res_valid", 32'(res_valid), 32'd1);
      check("dir_l1_res_data", 32'(res_data), 32'b0010);
      cmd_valid = 1'b1;
      cmd_n     = 2'd0;
      step();
      cmd_valid = 1'b0;
      step();
      check("dir_l0_sh_n", 32'(sh_n), 32'd0);
      step();
      check("dir_l0_res_data", 32'(res_data), 32'b0001);
      cmd_dir = 1'b0;
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
